// File: rtl/reserved_slot_arbiter.sv
// reserved_slot_arbiter
// Single clocked owner of the reserved-parking occupancy bitmap. Entry and exit
// gates share it through a round-robin arbiter; one request is in flight at a
// time (IDLE -> CHECK -> RESP) and every request returns one result code.
module reserved_slot_arbiter #(
    parameter int N = 16,
    parameter int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         entry_req_valid,
    output logic         entry_req_ready,
    input  logic [W-1:0] entry_flat,
    input  logic         exit_req_valid,
    output logic         exit_req_ready,
    input  logic [W-1:0] exit_flat,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_src,
    output logic [W-1:0] rsp_flat,
    output logic [2:0]   rsp_code,
    output logic [N-1:0] occ_map,
    output logic [W-1:0] occ_count,
    output logic         full,
    output logic         empty
);

    localparam logic [2:0] CODE_ENTERED  = 3'd0;
    localparam logic [2:0] CODE_EXITED   = 3'd1;
    localparam logic [2:0] CODE_OCCUPIED = 3'd2;
    localparam logic [2:0] CODE_EMPTY    = 3'd3;
    localparam logic [2:0] CODE_RANGE    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic           rr_last_r;      // 1 = exit gate won the last grant
    logic           lat_src_r;
    logic [W-1:0]   lat_flat_r;
    logic           grant_entry_s;
    logic           grant_exit_s;

    logic           rsp_valid_r;
    logic           rsp_src_r;
    logic [W-1:0]   rsp_flat_r;
    logic [2:0]     rsp_code_r;
    logic [N-1:0]   occ_map_r;
    logic [W-1:0]   occ_count_r;
    logic           full_r;
    logic           empty_r;

    logic           in_range_s;
    logic [N-1:0]   mask_s;
    logic           hit_s;
    logic [2:0]     code_s;
    logic [N-1:0]   map_next_s;
    logic [W-1:0]   count_next_s;

    // Next-state and round-robin grant; grants only exist in IDLE outside reset
    always_comb begin
        next_state_s  = state_r;
        grant_entry_s = 1'b0;
        grant_exit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rst) begin
                    next_state_s = ST_IDLE;
                end else if (entry_req_valid && exit_req_valid) begin
                    if (rr_last_r) begin
                        grant_entry_s = 1'b1;
                    end else begin
                        grant_exit_s = 1'b1;
                    end
                    next_state_s = ST_CHECK;
                end else if (entry_req_valid) begin
                    grant_entry_s = 1'b1;
                    next_state_s  = ST_CHECK;
                end else if (exit_req_valid) begin
                    grant_exit_s = 1'b1;
                    next_state_s = ST_CHECK;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                next_state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Result code and updated map/count for the latched request
    always_comb begin
        in_range_s   = (lat_flat_r != {W{1'b0}}) && (lat_flat_r <= W'(N));
        mask_s       = {N{1'b0}};
        code_s       = CODE_RANGE;
        map_next_s   = occ_map_r;
        count_next_s = occ_count_r;
        if (in_range_s) begin
            mask_s = {{(N-1){1'b0}}, 1'b1} << (lat_flat_r - W'(1));
        end else begin
            mask_s = {N{1'b0}};
        end
        hit_s = |(occ_map_r & mask_s);
        if (!in_range_s) begin
            code_s = CODE_RANGE;
        end else if (!lat_src_r) begin
            if (hit_s) begin
                code_s = CODE_OCCUPIED;
            end else begin
                code_s       = CODE_ENTERED;
                map_next_s   = occ_map_r | mask_s;
                count_next_s = occ_count_r + W'(1);
            end
        end else begin
            if (hit_s) begin
                code_s       = CODE_EXITED;
                map_next_s   = occ_map_r & ~mask_s;
                count_next_s = occ_count_r - W'(1);
            end else begin
                code_s = CODE_EMPTY;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latch, arbitration history, bitmap and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_r   <= 1'b1;
            lat_src_r   <= 1'b0;
            lat_flat_r  <= {W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_src_r   <= 1'b0;
            rsp_flat_r  <= {W{1'b0}};
            rsp_code_r  <= 3'd0;
            occ_map_r   <= {N{1'b0}};
            occ_count_r <= {W{1'b0}};
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
        end else begin
            if (grant_entry_s) begin
                lat_src_r  <= 1'b0;
                lat_flat_r <= entry_flat;
                rr_last_r  <= 1'b0;
            end else if (grant_exit_s) begin
                lat_src_r  <= 1'b1;
                lat_flat_r <= exit_flat;
                rr_last_r  <= 1'b1;
            end else begin
                lat_src_r  <= lat_src_r;
                lat_flat_r <= lat_flat_r;
                rr_last_r  <= rr_last_r;
            end
            if (state_r == ST_CHECK) begin
                occ_map_r   <= map_next_s;
                occ_count_r <= count_next_s;
                full_r      <= (count_next_s == W'(N));
                empty_r     <= (count_next_s == {W{1'b0}});
                rsp_valid_r <= 1'b1;
                rsp_src_r   <= lat_src_r;
                rsp_flat_r  <= lat_flat_r;
                rsp_code_r  <= code_s;
            end else if (rsp_valid_r && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

    assign entry_req_ready = grant_entry_s;
    assign exit_req_ready  = grant_exit_s;
    assign rsp_valid       = rsp_valid_r;
    assign rsp_src         = rsp_src_r;
    assign rsp_flat        = rsp_flat_r;
    assign rsp_code        = rsp_code_r;
    assign occ_map         = occ_map_r;
    assign occ_count       = occ_count_r;
    assign full            = full_r;
    assign empty           = empty_r;

endmodule

// File: tb/tb_reserved_slot_arbiter.sv
// Bench for reserved_slot_arbiter: directed scenarios plus randomized traffic.
// A reference model (per-flat occupancy array) predicts grants and results at
// acceptance time and pushes them to a scoreboard; the monitor pops and compares.
module tb_reserved_slot_arbiter;

    localparam int N = 16;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         entry_req_valid, entry_req_ready;
    logic [W-1:0] entry_flat;
    logic         exit_req_valid, exit_req_ready;
    logic [W-1:0] exit_flat;
    logic         rsp_valid, rsp_ready, rsp_src;
    logic [W-1:0] rsp_flat;
    logic [2:0]   rsp_code;
    logic [N-1:0] occ_map;
    logic [W-1:0] occ_count;
    logic         full, empty;

    reserved_slot_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .entry_req_valid(entry_req_valid), .entry_req_ready(entry_req_ready), .entry_flat(entry_flat),
        .exit_req_valid(exit_req_valid), .exit_req_ready(exit_req_ready), .exit_flat(exit_flat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_flat(rsp_flat),
        .rsp_code(rsp_code), .occ_map(occ_map), .occ_count(occ_count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         src;
        logic [W-1:0] flat;
        logic [2:0]   code;
        logic [N-1:0] map;
        int           count;
        int           acc_cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   rst_q = 1'b0;
    bit   fin = 1'b0;
    bit   fin_done = 1'b0;

    // Reference model state (owned by the monitor)
    bit   occ[1:N];
    bit   busy = 1'b0;
    bit   last_exit = 1'b1;
    bit   seen_first = 1'b0;
    int   stall = 0;

    // Stimulus queues (owned by the driver)
    int   eq[$];
    int   xq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int f = 1; f <= N; f++) c += occ[f];
        return c;
    endfunction

    function automatic logic [N-1:0] model_map();
        logic [N-1:0] v = '0;
        for (int f = 1; f <= N; f++) v[f-1] = occ[f];
        return v;
    endfunction

    // Result of one request per the parking rules; updates the model occupancy
    function automatic logic [2:0] model_apply(input bit src, input int flat);
        if (flat < 1 || flat > N) return 3'd4;
        if (!src) begin
            if (occ[flat]) return 3'd2;
            occ[flat] = 1'b1;
            return 3'd0;
        end else begin
            if (!occ[flat]) return 3'd3;
            occ[flat] = 1'b0;
            return 3'd1;
        end
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Monitor: predicts grants, feeds the scoreboard, checks responses
    always @(negedge clk) begin
        bit   exp_e, exp_x;
        exp_t e;
        if (rst) begin
            if (rst_q) begin
                check("rst_rsp", {rsp_valid, rsp_src, rsp_flat, rsp_code}, 32'd0);
                check("rst_occ_map", occ_map, 32'd0);
                check("rst_occ_count", occ_count, 32'd0);
                check("rst_full_empty", {full, empty}, 32'd1);
                check("rst_ready", {entry_req_ready, exit_req_ready}, 32'd0);
            end
            for (int f = 1; f <= N; f++) occ[f] = 1'b0;
            busy = 1'b0; last_exit = 1'b1; seen_first = 1'b0; stall = 0;
            sbq.delete();
        end else begin
            exp_e = 1'b0; exp_x = 1'b0;
            if (!busy) begin
                if (entry_req_valid && exit_req_valid) begin
                    if (last_exit) exp_e = 1'b1; else exp_x = 1'b1;
                end else if (entry_req_valid) exp_e = 1'b1;
                else if (exit_req_valid) exp_x = 1'b1;
            end
            check("ready", {entry_req_ready, exit_req_ready}, {exp_e, exp_x});
            if (exp_e || exp_x) begin
                e.src     = exp_x;
                e.flat    = exp_x ? exit_flat : entry_flat;
                e.code    = model_apply(exp_x, int'(e.flat));
                e.map     = model_map();
                e.count   = model_count();
                e.acc_cyc = cyc;
                sbq.push_back(e);
                last_exit = exp_x;
                busy      = 1'b1;
            end
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    if (!seen_first) begin
                        check("latency", cyc - sbq[0].acc_cyc, 32'd2);
                        seen_first = 1'b1;
                    end
                    check("rsp_fields", {rsp_src, rsp_flat, rsp_code},
                          {sbq[0].src, sbq[0].flat, sbq[0].code});
                    check("occ_map", occ_map, sbq[0].map);
                    check("occ_count", occ_count, sbq[0].count);
                    check("full_empty", {full, empty}, {sbq[0].count == N, sbq[0].count == 0});
                    if (rsp_ready) begin
                        void'(sbq.pop_front());
                        busy = 1'b0; seen_first = 1'b0; stall = 0;
                    end
                end
            end
            if (sbq.size() > 0) begin
                stall++;
                if (stall == 40) check("rsp_timeout", 32'd0, 32'd1);
            end
        end
        if (fin && !fin_done) begin
            check("scoreboard_drained", sbq.size() + int'(busy), 32'd0);
            fin_done = 1'b1;
        end
    end

    task automatic step(output bit ae, output bit ax);
        @(negedge clk);
        ae = entry_req_valid && entry_req_ready;
        ax = exit_req_valid && exit_req_ready;
        @(posedge clk);
        #1;
    endtask

    // Presents queued requests on both gates, holding each until accepted
    task automatic run_gates(input bit rnd);
        bit ae, ax;
        entry_req_valid = (eq.size() > 0);
        entry_flat      = (eq.size() > 0) ? W'(eq[0]) : '0;
        exit_req_valid  = (xq.size() > 0);
        exit_flat       = (xq.size() > 0) ? W'(xq[0]) : '0;
        for (int c = 0; c < 5000 && (eq.size() > 0 || xq.size() > 0); c++) begin
            step(ae, ax);
            if (ae && eq.size() > 0) void'(eq.pop_front());
            if (ax && xq.size() > 0) void'(xq.pop_front());
            rsp_ready       = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            entry_req_valid = (eq.size() > 0) && !(rnd && ae && $urandom_range(0, 2) == 0);
            entry_flat      = (eq.size() > 0) ? W'(eq[0]) : '0;
            exit_req_valid  = (xq.size() > 0) && !(rnd && ax && $urandom_range(0, 2) == 0);
            exit_flat       = (xq.size() > 0) ? W'(xq[0]) : '0;
        end
        entry_req_valid = 1'b0;
        exit_req_valid  = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; entry_req_valid = 1'b0; exit_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Driver
    initial begin
        bit ae, ax;
        rst = 1'b1; entry_req_valid = 1'b0; exit_req_valid = 1'b0;
        entry_flat = '0; exit_flat = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic entry/exit, duplicate entry, empty exit, out-of-range flats
        eq = '{3}; run_gates(1'b0); drain();
        eq = '{3}; run_gates(1'b0); drain();
        xq = '{5}; run_gates(1'b0); drain();
        xq = '{3}; run_gates(1'b0); drain();
        eq = '{0, 17}; run_gates(1'b0); drain();

        // Same-flat ties from reset: entry first, then exit wins the second tie
        pulse_reset();
        eq = '{2, 2}; xq = '{2}; run_gates(1'b0); drain();

        // Response back-pressure with a waiting exit request
        rsp_ready = 1'b0; entry_req_valid = 1'b1; entry_flat = 5'd7;
        for (int c = 0; c < 10; c++) begin step(ae, ax); if (ae) break; end
        entry_req_valid = 1'b0; exit_req_valid = 1'b1; exit_flat = 5'd7;
        repeat (7) step(ae, ax);
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin step(ae, ax); if (ax) break; end
        exit_req_valid = 1'b0;
        drain();

        // Fill all slots, then reset while a 17th request is in CHECK
        for (int f = 1; f <= N; f++) eq.push_back(f);
        run_gates(1'b0); drain();
        entry_req_valid = 1'b1; entry_flat = 5'd5;
        for (int c = 0; c < 10; c++) begin step(ae, ax); if (ae) break; end
        rst = 1'b1; entry_req_valid = 1'b0;
        step(ae, ax);
        step(ae, ax);
        rst = 1'b0;

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            int fl;
            fl = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 17));
            if ($urandom_range(0, 1) == 0) eq.push_back(fl); else xq.push_back(fl);
        end
        run_gates(1'b1); drain();

        fin = 1'b1;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
